regfile_writeback_queue: RTL

- Write-side front end for the 32 x 64 register file.
- Accepts results from two producers: the ALU result path and the memory load path, each over a valid/ready handshake.
- Buffers results in a small in-order FIFO and drains one register write per cycle onto the register file's data_in/address/write port.
- Exports a per-register pending mask so the hazard logic can stall readers of registers with queued writes.

---
 rtl/regfile_writeback_queue_pkg.sv | 15 +
 rtl/regfile_writeback_queue_if.sv | 47 ++++
 rtl/regfile_writeback_queue_writeback_fifo.sv | 67 ++++++
 rtl/regfile_writeback_queue.sv | 96 +++++++++
 4 files changed

// File: rtl/regfile_writeback_queue_pkg.sv
// Shared types and constants for the register-file writeback queue.
// The zero register is hardwired, so writes to it are dropped before the FIFO.
package regfile_writeback_queue_pkg;

    localparam int DEFAULT_WIDTH  = 64;
    localparam int DEFAULT_ADDR_W = 5;

    localparam logic [DEFAULT_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] address;
        logic [DEFAULT_WIDTH-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Producer handshakes, register-file write port and status of the writeback queue.
// master = producers/consumer side, slave = the queue itself.
interface regfile_writeback_queue_if
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_address;
    logic [WIDTH-1:0]  alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [WIDTH-1:0]  mem_data;

    logic [WIDTH-1:0]  rf_data;
    logic [ADDR_W-1:0] rf_address;
    logic              rf_write;

    logic [31:0]       pending;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport master (
        output alu_valid, alu_address, alu_data,
        output mem_valid, mem_address, mem_data,
        input  alu_ready, mem_ready,
        input  rf_data, rf_address, rf_write,
        input  pending, count, empty, full
    );

    modport slave (
        input  alu_valid, alu_address, alu_data,
        input  mem_valid, mem_address, mem_data,
        output alu_ready, mem_ready,
        output rf_data, rf_address, rf_write,
        output pending, count, empty, full
    );

endinterface

// File: rtl/regfile_writeback_queue_writeback_fifo.sv
// In-order FIFO with two pushes (push0 lands before push1) and one pop per cycle.
// Exposes per-slot valid bits and destination addresses for the pending mask.
module writeback_fifo
    import regfile_writeback_queue_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  ADDR_W  = DEFAULT_ADDR_W,
    parameter type entry_t = wb_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push0,
    input  entry_t                 push0_entry,
    input  logic                   push1,
    input  entry_t                 push1_entry,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic [ADDR_W-1:0]      entry_address [DEPTH],
    output logic [DEPTH-1:0]       entry_valid
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           slots [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] slot1;
    logic [CNT_W-1:0] cnt_q;

    // push1 alone still goes to wr_ptr so the FIFO never leaves a hole
    assign slot1 = push0 ? wr_ptr + PTR_W'(1) : wr_ptr;

    always_ff @(posedge clock) begin
        if (push0) slots[wr_ptr] <= push0_entry;
        if (push1) slots[slot1]  <= push1_entry;
    end

    // A slot freed by pop may be refilled on the same edge; the later set wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else begin
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            if (push0) vld_q[wr_ptr] <= 1'b1;
            if (push1) vld_q[slot1]  <= 1'b1;
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            cnt_q  <= cnt_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_addr
        assign entry_address[i] = slots[i].address;
    end

    assign head        = slots[rd_ptr];
    assign count       = cnt_q;
    assign entry_valid = vld_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback front end: filters zero-register writes, arbitrates mem (older) ahead of
// ALU into the FIFO, drains one register write per cycle and publishes the pending mask.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input logic                     clock,
    input logic                     reset,
    regfile_writeback_queue_if.slave wb
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [WIDTH-1:0]  data;
    } entry_t;

    entry_t            alu_entry;
    entry_t            mem_entry;
    entry_t            push0_entry;
    entry_t            head;
    logic [ADDR_W-1:0] entry_address [DEPTH];
    logic [DEPTH-1:0]  entry_valid;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  visible_count;
    logic [CNT_W-1:0]  free;
    logic              alu_zero, mem_zero;
    logic              alu_real, mem_real;
    logic              alu_push, mem_push;
    logic              push0, push1, pop;
    logic [31:0]       pending_c;

    assign alu_entry = '{address: wb.alu_address, data: wb.alu_data};
    assign mem_entry = '{address: wb.mem_address, data: wb.mem_data};

    assign alu_zero = (wb.alu_address == ADDR_W'(ZERO_REG));
    assign mem_zero = (wb.mem_address == ADDR_W'(ZERO_REG));
    assign alu_real = wb.alu_valid && !alu_zero;
    assign mem_real = wb.mem_valid && !mem_zero;

    // The head leaves on the same edge new entries land, so its slot counts as free.
    assign free = CNT_W'(DEPTH) - fifo_count + CNT_W'(fifo_count != '0);

    assign wb.mem_ready = !reset && (mem_zero || free >= CNT_W'(1));
    assign wb.alu_ready = !reset && (alu_zero ||
                                     (mem_real ? free >= CNT_W'(2) : free >= CNT_W'(1)));

    assign mem_push    = mem_real && wb.mem_ready;
    assign alu_push    = alu_real && wb.alu_ready;
    assign push0       = mem_push || alu_push;
    assign push0_entry = mem_push ? mem_entry : alu_entry;
    assign push1       = mem_push && alu_push;

    assign pop = !reset && (fifo_count != '0);

    writeback_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .entry_t(entry_t)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push0        (push0),
        .push0_entry  (push0_entry),
        .push1        (push1),
        .push1_entry  (alu_entry),
        .pop          (pop),
        .head         (head),
        .count        (fifo_count),
        .entry_address(entry_address),
        .entry_valid  (entry_valid)
    );

    always_comb begin
        pending_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) pending_c[entry_address[i]] = 1'b1;
        end
        pending_c[31] = 1'b0;
        if (reset) pending_c = '0;
    end

    assign visible_count = reset ? '0 : fifo_count;

    assign wb.rf_write   = pop;
    assign wb.rf_address = pop ? head.address : '0;
    assign wb.rf_data    = pop ? head.data : '0;
    assign wb.pending    = pending_c;
    assign wb.count      = visible_count;
    assign wb.empty      = (visible_count == '0);
    assign wb.full       = (visible_count == CNT_W'(DEPTH));

endmodule
